// File: rtl/aes_key_schedule_seq.sv
// AES-128 key expansion engine: one round key per handshake, with an 11-entry
// round-key table that the inverse cipher reads back in any order.

package aes_pkg;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-expansion step from w0..w3 (w0 in the top word)
    function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

module aes_key_schedule_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       rk_index,
    output logic             busy,
    output logic             table_valid,
    input  logic [3:0]       rd_index,
    output logic [KEY_W-1:0] rd_key
);
    import aes_pkg::*;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] work_q, work_d;
    logic [KEY_W-1:0] round_key_q, round_key_d;
    logic [3:0]       rk_index_q, rk_index_d;
    logic             rk_valid_q, rk_valid_d;
    logic             table_valid_q, table_valid_d;
    logic [KEY_W-1:0] rd_key_q;

    logic [KEY_W-1:0] table_q [0:NUM_ROUNDS];
    logic             tbl_we;
    logic [3:0]       tbl_waddr;
    logic [KEY_W-1:0] tbl_wdata;

    logic [3:0]       idx_next;
    logic [KEY_W-1:0] next_key;
    logic             handshake;

    assign idx_next  = rk_index_q + 4'd1;
    assign next_key  = next_round_key(work_q, rcon(idx_next));
    assign handshake = rk_valid_q && rk_ready;

    // Next-state and table-write decode for the four-state sequencer
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d       = state_q;
        work_d        = work_q;
        round_key_d   = round_key_q;
        rk_index_d    = rk_index_q;
        rk_valid_d    = rk_valid_q;
        table_valid_d = table_valid_q;
        tbl_we        = 1'b0;
        tbl_waddr     = idx_next;
        tbl_wdata     = next_key;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d        = key_in;
                    table_valid_d = 1'b0;
                    tbl_we        = 1'b1;
                    tbl_waddr     = 4'd0;
                    tbl_wdata     = key_in;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                round_key_d = work_q;
                rk_index_d  = 4'd0;
                rk_valid_d  = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    rk_valid_d = 1'b0;
                    state_d    = (rk_index_q == LAST_IDX) ? S_IDLE : S_EXPAND;
                end
            end
            S_EXPAND: begin
                work_d      = next_key;
                round_key_d = next_key;
                rk_index_d  = idx_next;
                rk_valid_d  = 1'b1;
                tbl_we      = 1'b1;
                if (idx_next == LAST_IDX) table_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
        if (!reset_n) begin
            state_q       <= S_IDLE;
            work_q        <= '0;
            round_key_q   <= '0;
            rk_index_q    <= 4'd0;
            rk_valid_q    <= 1'b0;
            table_valid_q <= 1'b0;
            rd_key_q      <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            round_key_q   <= round_key_d;
            rk_index_q    <= rk_index_d;
            rk_valid_q    <= rk_valid_d;
            table_valid_q <= table_valid_d;
            rd_key_q      <= (rd_index <= LAST_IDX) ? table_q[rd_index] : '0;
        end
    end

    // Round-key table write port
    always_ff @(posedge clock) begin
        // NOTE: the table has no reset; table_valid marks its contents stale instead.
        if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end

    assign rk_valid    = rk_valid_q;
    assign round_key   = round_key_q;
    assign rk_index    = rk_index_q;
    assign busy        = (state_q != S_IDLE);
    assign table_valid = table_valid_q;
    assign rd_key      = rd_key_q;

endmodule
